// File: rtl/seg_pipe_addsub.sv
// seg_pipe_addsub: pipelined wide add/subtract unit with segmented carry.
// The operands are split into SEGS segments of SEG_W bits. Stage 1 adds all
// segments in parallel. Each later stage propagates one inter-segment carry.
// The result leaves after SEGS cycles. A single enable (adv) moves the whole
// pipeline forward, so backpressure stalls every stage together.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline may advance)
//   sub                 0: Z = X+Y, 1: Z = X-Y
//   X, Y                unsigned operands (WIDTH bits)
//   in_tag / out_tag    user tag that travels with the operation
//   out_valid/out_ready output handshake
//   Z                   result mod 2^WIDTH
//   carry               add: carry out; sub: 1 = no borrow
module seg_pipe_addsub #(
  parameter int unsigned WIDTH = 272,
  parameter int unsigned SEGS  = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SEG_W = WIDTH / SEGS;
  localparam int unsigned SW1   = SEG_W + 1;

  if ((SEGS < 1) || ((WIDTH % SEGS) != 0)) begin : g_param_check
    $error("seg_pipe_addsub: WIDTH must be a non-zero multiple of SEGS");
  end

  // Each segment keeps its own carry bit in position SEG_W.
  typedef logic [SEGS-1:0][SEG_W:0] stage_t;

  stage_t           seg_q [SEGS];
  stage_t           seg_d [SEGS];
  logic [SEGS-1:0]  vld_q;
  logic [SEGS-1:0]  vld_d;
  logic [TAG_W-1:0] tag_q [SEGS];
  logic [TAG_W-1:0] tag_d [SEGS];
  logic             adv;

  // Whole-pipeline enable: move forward unless a result is stuck at the output.
  assign adv       = !vld_q[SEGS-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[SEGS-1];
  assign out_tag   = tag_q[SEGS-1];
  assign carry     = seg_q[SEGS-1][SEGS-1][SEG_W];

  // Result assembly: the low SEG_W bits of every resolved segment.
  always_comb begin
    Z = '0;
    for (int k = 0; k < SEGS; k++) begin
      Z[k*SEG_W +: SEG_W] = seg_q[SEGS-1][k][SEG_W-1:0];
    end
  end

  // Next-state: stage 1 adds segments; stage s resolves segment s.
  always_comb begin
    logic [SEG_W-1:0] x_k;
    logic [SEG_W-1:0] y_k;
    seg_d = seg_q;
    tag_d = tag_q;
    vld_d = vld_q;
    x_k   = '0;
    y_k   = '0;
    if (adv) begin
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int k = 0; k < SEGS; k++) begin
        x_k = X[k*SEG_W +: SEG_W];
        y_k = sub ? ~Y[k*SEG_W +: SEG_W] : Y[k*SEG_W +: SEG_W];
        // The +1 of the two's complement enters only at the bottom segment.
        seg_d[0][k] = {1'b0, x_k} + {1'b0, y_k} + SW1'((k == 0) && sub);
      end
      for (int s = 1; s < SEGS; s++) begin
        vld_d[s] = vld_q[s-1];
        tag_d[s] = tag_q[s-1];
        seg_d[s] = seg_q[s-1];
        // Segment s-1 was resolved one stage earlier; its carry bit is final.
        seg_d[s][s] = seg_q[s-1][s] + SW1'(seg_q[s-1][s-1][SEG_W]);
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < SEGS; s++) begin
        seg_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      seg_q <= seg_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Testbench for seg_pipe_addsub: a 16-bit/4-segment instance for directed
// scenarios plus 272-bit instances with SEGS = 1, 2, 4, 8 for a random sweep.
module tb_seg_pipe_addsub;

  localparam int unsigned MW   = 16;
  localparam int unsigned MS   = 4;
  localparam int unsigned MT   = 4;
  localparam int unsigned SWID = 272;
  localparam int unsigned ST   = 8;
  localparam int          NI   = 4;
  localparam int          NOPS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  // 16-bit instance
  logic          m_in_valid, m_in_ready, m_sub, m_out_valid, m_out_ready, m_carry;
  logic [MW-1:0] m_x, m_y, m_z;
  logic [MT-1:0] m_in_tag, m_out_tag;

  seg_pipe_addsub #(.WIDTH(MW), .SEGS(MS), .TAG_W(MT)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .sub(m_sub), .X(m_x), .Y(m_y), .in_tag(m_in_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .Z(m_z),
    .carry(m_carry), .out_tag(m_out_tag)
  );

  // 272-bit sweep instances share their inputs
  logic            s_in_valid, s_sub, s_out_ready;
  logic [SWID-1:0] s_x, s_y;
  logic [ST-1:0]   s_in_tag;
  logic            s_in_ready [NI];
  logic            s_out_valid [NI];
  logic            s_carry [NI];
  logic [SWID-1:0] s_z [NI];
  logic [ST-1:0]   s_out_tag [NI];

  for (genvar g = 0; g < NI; g++) begin : g_sweep
    seg_pipe_addsub #(.WIDTH(SWID), .SEGS(1 << g), .TAG_W(ST)) u_dut (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[g]),
      .sub(s_sub), .X(s_x), .Y(s_y), .in_tag(s_in_tag),
      .out_valid(s_out_valid[g]), .out_ready(s_out_ready), .Z(s_z[g]),
      .carry(s_carry[g]), .out_tag(s_out_tag[g])
    );
  end

  typedef struct {
    logic [SWID:0] res;
    logic [ST-1:0] tag;
    int            acc;
    int            stl;
  } sb_t;

  sb_t sb [NI][64];
  int  wp [NI];
  int  rp [NI];
  int  stl [NI];
  int  nacc [NI];

  // Reference: add gives the (WIDTH+1)-bit sum; sub gives X-Y mod 2^W, carry = no borrow.
  function automatic logic [MW:0] ref_m(input logic [MW-1:0] x, input logic [MW-1:0] y,
                                        input logic s);
    logic [MW-1:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [SWID:0] ref_w(input logic [SWID-1:0] x, input logic [SWID-1:0] y,
                                          input logic s);
    logic [SWID-1:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [SWID-1:0] rnd_wide();
    logic [SWID-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[SWID-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one op to an idle 16-bit pipe and waits (bounded) for its result.
  task automatic run_one(input logic [MW-1:0] x, input logic [MW-1:0] y, input logic s,
                         input logic [MT-1:0] t, output logic [MW-1:0] z, output logic c,
                         output logic [MT-1:0] ot, output int lat);
    m_x = x; m_y = y; m_sub = s; m_in_tag = t;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    lat = -1; z = '0; c = 1'b0; ot = '0;
    tick();
    m_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_out_valid) begin
        z = m_z; c = m_carry; ot = m_out_tag; lat = i;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_in_valid = 1'b1; m_x = 16'h00AA; m_y = 16'h0055; m_sub = 1'b0;
    m_in_tag = 4'hA; m_out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; m_in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", m_out_valid); end
    n_cmp++; if (m_z !== 16'h0000) begin n_fail++; $display("FAIL reset_z got %h want 0000", m_z); end
    n_cmp++; if (m_carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", m_carry); end
    n_cmp++; if (m_out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", m_out_tag); end
    n_cmp++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", m_in_ready); end
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (s_out_valid[i] !== 1'b0 || s_z[i] !== '0 || s_carry[i] !== 1'b0)
        begin n_fail++; $display("FAIL reset_sweep inst=%0d got v=%b c=%b want v=0 c=0 z=0", i, s_out_valid[i], s_carry[i]); end
    end
    // The op offered alongside reset must never emerge.
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle cycle=%0d got out_valid=%b want 0", i, m_out_valid); end
    end
    tick();
  endtask

  task automatic test_carry_ripple();
    logic [MW-1:0] z; logic c; logic [MT-1:0] t; int lat;
    run_one(16'hFFFF, 16'h0001, 1'b0, 4'd3, z, c, t, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL ripple_latency got %0d want 4", lat); end
    n_cmp++; if (z !== 16'h0000) begin n_fail++; $display("FAIL ripple_z got %h want 0000", z); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL ripple_carry got %b want 1", c); end
    n_cmp++; if (t !== 4'd3) begin n_fail++; $display("FAIL ripple_tag got %h want 3", t); end
  endtask

  task automatic test_subtract();
    logic [MW-1:0] z; logic c; logic [MT-1:0] t; int lat;
    run_one(16'h0000, 16'h0001, 1'b1, 4'd9, z, c, t, lat);
    n_cmp++; if (z !== 16'hFFFF || c !== 1'b0 || lat !== 4)
      begin n_fail++; $display("FAIL sub_borrow got z=%h c=%b lat=%0d want z=ffff c=0 lat=4", z, c, lat); end
    n_cmp++; if (t !== 4'd9) begin n_fail++; $display("FAIL sub_borrow_tag got %h want 9", t); end
    run_one(16'h1234, 16'h1234, 1'b1, 4'd6, z, c, t, lat);
    n_cmp++; if (z !== 16'h0000 || c !== 1'b1)
      begin n_fail++; $display("FAIL sub_equal got z=%h c=%b want z=0000 c=1", z, c); end
    run_one(16'h8000, 16'h7FFF, 1'b1, 4'd1, z, c, t, lat);
    n_cmp++; if (z !== 16'h0001 || c !== 1'b1)
      begin n_fail++; $display("FAIL sub_cross got z=%h c=%b want z=0001 c=1", z, c); end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] xs [8];
    logic [MW-1:0] ys [8];
    logic          ss [8];
    logic [MW:0]   e;
    logic [MW-1:0] hz;
    logic [MT-1:0] ht;
    int sent, got;
    sent = 0; got = 0; hz = '0; ht = '0;
    for (int i = 0; i < 8; i++) begin
      xs[i] = MW'($urandom); ys[i] = MW'($urandom); ss[i] = 1'($urandom);
    end
    for (int c = 0; c < 60 && got < 8; c++) begin
      m_in_valid = (sent < 8);
      if (sent < 8) begin
        m_x = xs[sent]; m_y = ys[sent]; m_sub = ss[sent]; m_in_tag = MT'(sent);
      end
      m_out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      if (c >= 5 && c <= 7) begin
        n_cmp++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle=%0d got %b want 0", c, m_in_ready); end
        n_cmp++; if (m_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid cycle=%0d got %b want 1", c, m_out_valid); end
        if (c == 5) begin
          hz = m_z; ht = m_out_tag;
        end else begin
          n_cmp++; if (m_z !== hz || m_out_tag !== ht)
            begin n_fail++; $display("FAIL stall_hold cycle=%0d got z=%h tag=%h want z=%h tag=%h", c, m_z, m_out_tag, hz, ht); end
        end
      end
      if (m_out_valid && m_out_ready) begin
        if (got < 8) begin
          e = ref_m(xs[got], ys[got], ss[got]);
          n_cmp++; if ({m_carry, m_z} !== e)
            begin n_fail++; $display("FAIL b2b_data idx=%0d got %h want %h", got, {m_carry, m_z}, e); end
          n_cmp++; if (m_out_tag !== MT'(got))
            begin n_fail++; $display("FAIL b2b_tag idx=%0d got %h want %h", got, m_out_tag, MT'(got)); end
          got++;
        end else begin
          n_cmp++; n_fail++; $display("FAIL b2b_extra got unexpected result tag=%h want none", m_out_tag);
        end
      end
      if (m_in_valid && m_in_ready) sent++;
      tick();
    end
    m_in_valid = 1'b0;
    n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", got); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain cycle=%0d got out_valid=%b want 0", i, m_out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] z; logic c; logic [MT-1:0] t; int lat;
    logic [MW:0] e;
    m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_in_valid = 1'b1; m_x = MW'($urandom); m_y = MW'($urandom); m_sub = 1'b0;
      m_in_tag = MT'(i + 1);
      rst = (i == 2);
      tick();
    end
    rst = 1'b0; m_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush cycle=%0d got out_valid=%b want 0", i, m_out_valid); end
      tick();
    end
    e = ref_m(16'hC3A5, 16'h5A5B, 1'b0);
    run_one(16'hC3A5, 16'h5A5B, 1'b0, 4'd7, z, c, t, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_latency got %0d want 4", lat); end
    n_cmp++; if ({c, z} !== e || t !== 4'd7)
      begin n_fail++; $display("FAIL rstmid_data got %h tag=%h want %h tag=7", {c, z}, t, e); end
  endtask

  task automatic test_sweep();
    bit  all_acc, all_empty;
    int  r;
    sb_t e;
    for (int i = 0; i < NI; i++) begin
      wp[i] = 0; rp[i] = 0; stl[i] = 0; nacc[i] = 0;
    end
    for (int c = 0; c < 40000; c++) begin
      all_acc = 1'b1;
      for (int i = 0; i < NI; i++) if (nacc[i] < NOPS) all_acc = 1'b0;
      s_in_valid = !all_acc && ($urandom_range(0, 9) < 8);
      s_x = rnd_wide(); s_y = rnd_wide();
      r = $urandom_range(0, 7);
      if (r == 0) s_y = s_x;
      else if (r == 1) s_y = ~s_x;
      else if (r == 2) s_x = '1;
      s_sub = 1'($urandom);
      s_in_tag = ST'($urandom);
      s_out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (s_out_valid[i] && s_out_ready) begin
          if (rp[i] == wp[i]) begin
            n_cmp++; n_fail++; $display("FAIL sweep_spurious segs=%0d got result with nothing pending want none", 1 << i);
          end else begin
            e = sb[i][rp[i] % 64];
            n_cmp++; if ({s_carry[i], s_z[i]} !== e.res)
              begin n_fail++; $display("FAIL sweep_data segs=%0d got %h want %h", 1 << i, {s_carry[i], s_z[i]}, e.res); end
            n_cmp++; if (s_out_tag[i] !== e.tag)
              begin n_fail++; $display("FAIL sweep_tag segs=%0d got %h want %h", 1 << i, s_out_tag[i], e.tag); end
            // Cycles from accept to retire = SEGS + stall cycles in between.
            n_cmp++; if ((c - e.acc - (1 << i)) !== (stl[i] - e.stl))
              begin n_fail++; $display("FAIL sweep_latency segs=%0d got %0d want %0d", 1 << i, c - e.acc, (1 << i) + stl[i] - e.stl); end
            rp[i]++;
          end
        end
        if (s_in_valid && s_in_ready[i]) begin
          sb[i][wp[i] % 64].res = ref_w(s_x, s_y, s_sub);
          sb[i][wp[i] % 64].tag = s_in_tag;
          sb[i][wp[i] % 64].acc = c;
          sb[i][wp[i] % 64].stl = stl[i];
          wp[i]++; nacc[i]++;
        end
        if (!s_in_ready[i]) stl[i]++;
      end
      tick();
      all_empty = 1'b1;
      for (int i = 0; i < NI; i++) if (rp[i] != wp[i]) all_empty = 1'b0;
      if (all_acc && all_empty) break;
    end
    s_in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (nacc[i] < NOPS || rp[i] != wp[i])
        begin n_fail++; $display("FAIL sweep_done segs=%0d got accepted=%0d pending=%0d want accepted>=%0d pending=0", 1 << i, nacc[i], wp[i] - rp[i], NOPS); end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_in_valid = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
    m_x = '0; m_y = '0; m_in_tag = '0;
    s_in_valid = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    s_x = '0; s_y = '0; s_in_tag = '0;
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
